// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the WB stage and a
// 2-entry in-order FIFO of long-latency (mul/div) results.
//   clk, resetn                    clock, async active-low reset
//   ws_rf_we/waddr/wdata           WB-stage write request (we==0: no write)
//   lu_valid/waddr/wdata, lu_ready long-latency result handshake
//   ws_stall                       WB write not granted this cycle, hold WB
//   rf_we/waddr/wdata              register-file write port
//   pend_mask, fifo_cnt            live buffered destinations, buffered entry count
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  ws_rf_we,
    input  logic [4:0]  ws_rf_waddr,
    input  logic [31:0] ws_rf_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic        ws_stall,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pend_mask,
    output logic [1:0]  fifo_cnt
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [4:0]    q_addr [2];
    logic [31:0]   q_data [2];
    logic [1:0]    q_live;
    logic          rp, wp;
    logic [1:0]    cnt;
    logic [SW-1:0] starve;
    logic          head_valid, head_live, grant_head, pop, push, wb_wr;

    assign head_valid = cnt != 2'd0;
    assign head_live  = head_valid && q_live[rp];
    assign grant_head = head_live && (ws_rf_we == 4'd0 || starve == SMAX);
    // a dead head leaves without using the write port
    assign pop        = head_valid && (grant_head || !q_live[rp]);
    assign lu_ready   = cnt != 2'd2;
    // results for r0 are acknowledged but never buffered
    assign push       = lu_valid && lu_ready && lu_waddr != 5'd0;
    assign wb_wr      = !grant_head && ws_rf_we != 4'd0;
    assign ws_stall   = grant_head && ws_rf_we != 4'd0;
    assign rf_we      = grant_head ? 4'hF : ws_rf_we;
    assign rf_waddr   = grant_head ? q_addr[rp] : ws_rf_waddr;
    assign rf_wdata   = grant_head ? q_data[rp] : ws_rf_wdata;
    assign fifo_cnt   = cnt;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++)
            if (q_live[i] && ((1'(i) == rp) ? head_valid : cnt == 2'd2))
                pend_mask[q_addr[i]] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk)
        if (push) begin
            q_addr[wp] <= lu_waddr;
            q_data[wp] <= lu_wdata;
        end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            q_live <= '0;
            rp     <= 1'b0;
            wp     <= 1'b0;
            cnt    <= 2'd0;
            starve <= '0;
        end else begin
            // a newer WB write to the same register makes the buffered result stale;
            // the entry being enqueued this cycle is younger, so it is set live after
            for (int i = 0; i < 2; i++)
                if (wb_wr && q_addr[i] == ws_rf_waddr)
                    q_live[i] <= 1'b0;
            if (push) q_live[wp] <= 1'b1;
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            cnt    <= cnt + {1'b0, push} - {1'b0, pop};
            starve <= (pop || !head_valid) ? '0 :
                      (head_live && !grant_head && starve != SMAX) ? starve + 1'b1 : starve;
        end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scoreboard bench for rf_wb_arbiter (STARVE_MAX=4).
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  ws_rf_we = '0;
    logic [4:0]  ws_rf_waddr = '0;
    logic [31:0] ws_rf_wdata = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_waddr = '0;
    logic [31:0] lu_wdata = '0;
    logic        lu_ready, ws_stall;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pend_mask;
    logic [1:0]  fifo_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        rdy;
        logic [31:0] pm;
        logic [1:0]  cnt;
    } exp_t;
    exp_t q[$];

    rf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .lu_ready(lu_ready), .ws_stall(ws_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    // monitor: the DUT presents a combinational response every cycle
    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
            chk("rf_wdata", rf_wdata, e.wd);
            chk("ws_stall", 32'(ws_stall), 32'(e.st));
            chk("lu_ready", 32'(lu_ready), 32'(e.rdy));
            chk("pend_mask", pend_mask, e.pm);
            chk("fifo_cnt", 32'(fifo_cnt), 32'(e.cnt));
        end

    task automatic step(input logic [3:0] we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic v, input logic [4:0] la, input logic [31:0] ld,
                        input logic [3:0] e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                        input logic e_st, input logic e_rdy, input logic [31:0] e_pm,
                        input logic [1:0] e_cnt);
        ws_rf_we = we; ws_rf_waddr = wa; ws_rf_wdata = wd;
        lu_valid = v; lu_waddr = la; lu_wdata = ld;
        q.push_back('{e_we, e_wa, e_wd, e_st, e_rdy, e_pm, e_cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        // in reset: WB passes through, LU ignored
        step(0, 0, 0,        0, 0, 0,         0, 0, 0,          0, 1, 0, 0);
        step(4'hF, 3, 'h1234, 1, 5, 'hAAAA,  4'hF, 3, 'h1234,  0, 1, 0, 0);
        resetn = 1'b1;
        // idle FIFO, WB write passes through
        step(4'hF, 3, 'h1234, 0, 0, 0,       4'hF, 3, 'h1234,  0, 1, 0, 0);
        // single LU result drains on an idle WB cycle
        step(0, 0, 0,        1, 5, 'hAAAA,    0, 0, 0,          0, 1, 0, 0);
        step(0, 0, 0,        0, 0, 0,         4'hF, 5, 'hAAAA,  0, 1, 32'h20, 1);
        step(0, 0, 0,        0, 0, 0,         0, 0, 0,          0, 1, 0, 0);
        // starvation: 4 WB grants, then head preempts with a stall
        step(4'hF, 8, 'h88,  1, 7, 'h7777,   4'hF, 8, 'h88,    0, 1, 0, 0);
        step(4'hF, 8, 'h88,  0, 0, 0,        4'hF, 8, 'h88,    0, 1, 32'h80, 1);
        step(4'hF, 8, 'h88,  0, 0, 0,        4'hF, 8, 'h88,    0, 1, 32'h80, 1);
        step(4'hF, 8, 'h88,  0, 0, 0,        4'hF, 8, 'h88,    0, 1, 32'h80, 1);
        step(4'hF, 8, 'h88,  0, 0, 0,        4'hF, 8, 'h88,    0, 1, 32'h80, 1);
        step(4'hF, 8, 'h88,  0, 0, 0,        4'hF, 7, 'h7777,  1, 1, 32'h80, 1);
        step(4'hF, 8, 'h88,  0, 0, 0,        4'hF, 8, 'h88,    0, 1, 0, 0);
        // fill FIFO, third result held, then in-order drain with enqueue+pop
        step(4'hF, 8, 'h88,  1, 10, 'hA0,    4'hF, 8, 'h88,    0, 1, 0, 0);
        step(4'hF, 8, 'h88,  1, 11, 'hB0,    4'hF, 8, 'h88,    0, 1, 32'h400, 1);
        step(4'hF, 8, 'h88,  1, 12, 'hC0,    4'hF, 8, 'h88,    0, 0, 32'hC00, 2);
        step(0, 0, 0,        1, 12, 'hC0,    4'hF, 10, 'hA0,   0, 0, 32'hC00, 2);
        step(0, 0, 0,        1, 12, 'hC0,    4'hF, 11, 'hB0,   0, 1, 32'h800, 1);
        step(0, 0, 0,        0, 0, 0,        4'hF, 12, 'hC0,   0, 1, 32'h1000, 1);
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        // WB squashes buffered r9; dead head popped silently
        step(0, 0, 0,        1, 9, 'h99,     0, 0, 0,          0, 1, 0, 0);
        step(4'hF, 9, 'h999, 0, 0, 0,        4'hF, 9, 'h999,   0, 1, 32'h200, 1);
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 1);
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        // same-cycle enqueue and WB write to r13: entry stays live
        step(4'hF, 13, 'hD1, 1, 13, 'hD2,    4'hF, 13, 'hD1,   0, 1, 0, 0);
        step(0, 0, 0,        0, 0, 0,        4'hF, 13, 'hD2,   0, 1, 32'h2000, 1);
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        // r0 result accepted but not buffered
        step(0, 0, 0,        1, 0, 'h55,     0, 0, 0,          0, 1, 0, 0);
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        // mid-operation reset discards two buffered results
        step(4'hF, 8, 'h88,  1, 14, 'hE0,    4'hF, 8, 'h88,    0, 1, 0, 0);
        step(4'hF, 8, 'h88,  1, 15, 'hF0,    4'hF, 8, 'h88,    0, 1, 32'h4000, 1);
        resetn = 1'b0;
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        resetn = 1'b1;
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        step(0, 0, 0,        0, 0, 0,        0, 0, 0,          0, 1, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: cycles a buffered long-latency result may be denied the RF write port before it preempts WB.
REQ-002 SHALL have port clk  in  1  sole clock; all state rising-edge.
REQ-003 SHALL have port resetn  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ws_rf_we  in  4  WB-stage byte write enables; 0 means no write.
REQ-005 SHALL have port ws_rf_waddr  in  5  WB-stage destination register.
REQ-006 SHALL have port ws_rf_wdata  in  32  WB-stage write data.
REQ-007 SHALL have port lu_valid  in  1  long-latency unit (mul/div) result valid.
REQ-008 SHALL have port lu_waddr  in  5  long-latency result destination.
REQ-009 SHALL have port lu_wdata  in  32  long-latency result data.
REQ-010 SHALL have port lu_ready  out  1  arbiter can accept an LU result this cycle.
REQ-011 SHALL have port ws_stall  out  1  hold WB stage; its write was not granted.
REQ-012 SHALL have port rf_we  out  4  register-file write enables.
REQ-013 SHALL have port rf_waddr  out  5  register-file write address.
REQ-014 SHALL have port rf_wdata  out  32  register-file write data.
REQ-015 SHALL have port pend_mask  out  32  bit i set: live buffered result pending for register i.
REQ-016 SHALL have port fifo_cnt  out  2  buffered entry count, 0..2.

Function
REQ-017 SHALL hold LU results in a 2-entry in-order FIFO; each entry holds waddr, wdata, live bit.
REQ-018 SHALL drive lu_ready = (fifo_cnt < 2); no enqueue when full, even if the head drains that cycle.
REQ-019 SHALL enqueue on lu_valid && lu_ready; an entry with lu_waddr == 0 is accepted but not stored (fifo_cnt unchanged).
REQ-020 SHALL grant the write port to the FIFO head when its entry is live and (ws_rf_we == 0 or starve == STARVE_MAX); otherwise it SHALL grant WB.
REQ-021 Head grant SHALL drive rf_we=4'b1111, rf_waddr/rf_wdata from the head, and pop the head at the clock edge.
REQ-022 WB grant SHALL pass ws_rf_we/waddr/wdata to rf_* unchanged, same cycle (zero latency, combinational).
REQ-023 ws_stall SHALL be 1 exactly when the head is granted while ws_rf_we != 0; WB re-presents next cycle.
REQ-024 The starve counter SHALL increment (saturating at STARVE_MAX) each cycle a live head exists and WB is granted with nonzero ws_rf_we; it SHALL clear when the head pops or the FIFO is empty.
REQ-025 A granted WB write with nonzero ws_rf_we SHALL clear the live bit of every stored entry whose waddr equals ws_rf_waddr (squash of stale older result).
REQ-026 An entry enqueued in the same cycle as a matching WB write SHALL NOT be squashed.
REQ-027 A dead entry at the head SHALL be popped in one cycle without an RF write and without asserting ws_stall; WB is granted that cycle.
REQ-028 Simultaneous enqueue and pop SHALL leave fifo_cnt unchanged; the new entry goes behind the remaining one.
REQ-029 pend_mask SHALL be derived from current FIFO state only; bit 0 SHALL always be 0.
REQ-030 Pointers SHALL wrap modulo 2; fifo_cnt SHALL never exceed 2 or underflow.

Reset
REQ-031 On resetn low, asynchronously: fifo_cnt=0, all entries dead, pointers=0, starve=0.
REQ-032 During/after reset: lu_ready=1, ws_stall=0, pend_mask=0; rf_* follow ws_rf_* (WB grant).
REQ-033 Reset asserted mid-operation SHALL discard all buffered results without any RF write.

Verification
REQ-034 Idle FIFO, ws_rf_we=4'hF, waddr=3, wdata=0x1234 -> rf_we=F, rf_waddr=3, rf_wdata=0x1234 same cycle, ws_stall=0.
REQ-035 LU result waddr=5, data=0xAAAA, WB idle next cycle -> pend_mask=0x20, then rf_we=F/waddr=5/0xAAAA, fifo_cnt 1->0.
REQ-036 LU entry waddr=7, WB writing r8 every cycle, STARVE_MAX=4 -> WB granted 4 cycles, 5th cycle head granted, ws_stall=1 one cycle, starve clears.
REQ-037 Two LU entries fill FIFO -> lu_ready=0, third lu_valid held; one pop -> lu_ready=1 next cycle, third accepted in order.
REQ-038 LU entry waddr=9 buffered, WB writes r9 -> entry dead, pend_mask[9]=0, entry popped next cycle with rf_we=0 from FIFO, no stall.
REQ-039 FIFO holds 2 entries, resetn pulsed low mid-cycle -> fifo_cnt=0, pend_mask=0 immediately, no buffered write ever reaches RF.
